// File: rtl/jt7759_pkg.sv
// Shared uPD7759 ADPCM tables and helpers, used by both the jt7759 decoder and encoder.
package jt7759_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, UPDATE} enc_state_e;

  localparam int STEP [16][16] = '{
    '{0,  0,  1,  2,  3,   5,   7,  10,  0,   0,  -1,  -2,  -3,   -5,   -7,  -10},
    '{0,  1,  2,  3,  4,   6,   8,  13,  0,  -1,  -2,  -3,  -4,   -6,   -8,  -13},
    '{0,  1,  2,  4,  5,   7,  10,  15,  0,  -1,  -2,  -4,  -5,   -7,  -10,  -15},
    '{0,  1,  3,  4,  6,   9,  13,  19,  0,  -1,  -3,  -4,  -6,   -9,  -13,  -19},
    '{0,  2,  3,  5,  8,  11,  15,  23,  0,  -2,  -3,  -5,  -8,  -11,  -15,  -23},
    '{0,  2,  4,  7, 10,  14,  19,  29,  0,  -2,  -4,  -7, -10,  -14,  -19,  -29},
    '{0,  3,  5,  8, 12,  16,  22,  33,  0,  -3,  -5,  -8, -12,  -16,  -22,  -33},
    '{1,  4,  7, 10, 15,  20,  29,  43, -1,  -4,  -7, -10, -15,  -20,  -29,  -43},
    '{1,  4,  8, 13, 18,  25,  35,  53, -1,  -4,  -8, -13, -18,  -25,  -35,  -53},
    '{1,  6, 10, 16, 22,  31,  43,  64, -1,  -6, -10, -16, -22,  -31,  -43,  -64},
    '{2,  7, 12, 19, 27,  37,  51,  76, -2,  -7, -12, -19, -27,  -37,  -51,  -76},
    '{2,  9, 16, 24, 34,  46,  64,  96, -2,  -9, -16, -24, -34,  -46,  -64,  -96},
    '{3, 11, 19, 29, 41,  57,  79, 117, -3, -11, -19, -29, -41,  -57,  -79, -117},
    '{4, 13, 24, 36, 50,  69,  96, 143, -4, -13, -24, -36, -50,  -69,  -96, -143},
    '{4, 16, 29, 44, 62,  85, 118, 175, -4, -16, -29, -44, -62,  -85, -118, -175},
    '{6, 20, 36, 54, 76, 104, 144, 214, -6, -20, -36, -54, -76, -104, -144, -214}
  };

  localparam int ADJ [8] = '{-1, -1, 0, 0, 1, 2, 2, 3};

  function automatic logic signed [8:0] pred_next(input logic signed [8:0] prev,
                                                  input logic [3:0] st,
                                                  input logic [3:0] n);
    logic signed [9:0] sum;
    sum = 10'(prev) + 10'(STEP[st][n]);
    if (sum > 10'sd255) return 9'sd255;
    if (sum < -10'sd256) return 9'sh100;
    return sum[8:0];
  endfunction

  function automatic logic [3:0] state_next(input logic [3:0] st, input logic [3:0] n);
    int t;
    t = int'(st) + ADJ[n[2:0]];
    if (t < 0) t = 0;
    else if (t > 15) t = 15;
    return 4'(t);
  endfunction

  function automatic logic [9:0] abs_err(input logic signed [8:0] a, input logic signed [8:0] b);
    logic signed [9:0] d;
    d = 10'(a) - 10'(b);
    return d[9] ? 10'(-d) : d;
  endfunction

endpackage

// File: rtl/jt7759_enc_pack.sv
// Pairs committed nibbles into uPD7759 bytes, pads on flush, and owns the dout handshake.
module jt7759_enc_pack
  import jt7759_pkg::*;
#(
  parameter int HI_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       restart,
  input  logic       flush_en,
  input  logic       commit,
  input  logic [3:0] nibble,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready
);

  logic       held_q, held_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;

  function automatic logic [7:0] pair(input logic [3:0] first, input logic [3:0] second);
    return (HI_FIRST != 0) ? {first, second} : {second, first};
  endfunction

  always_comb begin
    held_d       = held_q;
    hold_d       = hold_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    // Consumption is not gated by cen so a fast sink never stalls on slow encoder ticks.
    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
    if (cen) begin
      if (restart) begin
        held_d = 1'b0;
      end else if (commit) begin
        if (held_q) begin
          dout_d       = pair(hold_q, nibble);
          dout_valid_d = 1'b1;
          held_d       = 1'b0;
        end else begin
          hold_d = nibble;
          held_d = 1'b1;
        end
      end else if (flush_en && held_q && !dout_valid_q) begin
        dout_d       = pair(hold_q, 4'h0);
        dout_valid_d = 1'b1;
        held_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q       <= 1'b0;
      hold_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      held_q       <= held_d;
      hold_q       <= hold_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: rtl/jt7759_encoder.sv
// uPD7759 ADPCM encoder: exhaustive 16-candidate search per sample, one candidate per cen tick.
// Optional JT7759_ENC_DEBUG_EN adds debug_nibble/debug_state/debug_pred outputs.
module jt7759_encoder
  import jt7759_pkg::*;
#(
  parameter int HI_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              restart,
  input  logic signed [8:0] pcm_in,
  input  logic              pcm_valid,
  output logic              pcm_ready,
  input  logic              flush,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready
`ifdef JT7759_ENC_DEBUG_EN
  ,
  output logic [3:0]        debug_nibble,
  output logic [3:0]        debug_state,
  output logic [8:0]        debug_pred
`endif
);

  enc_state_e        st_q, st_d;
  logic signed [8:0] prev_q, prev_d;
  logic [3:0]        sidx_q, sidx_d;
  logic [3:0]        n_q, n_d;
  logic [3:0]        best_n_q, best_n_d;
  logic [9:0]        best_err_q, best_err_d;
  logic signed [8:0] sample_q, sample_d;
  logic signed [8:0] cand;
  logic [9:0]        cand_err;
`ifdef JT7759_ENC_DEBUG_EN
  logic [3:0]        dbg_nib_q, dbg_nib_d;
`endif

  assign cand      = pred_next(prev_q, sidx_q, n_q);
  assign cand_err  = abs_err(sample_q, cand);
  assign pcm_ready = (st_q == IDLE) && !dout_valid;

  always_comb begin
    st_d       = st_q;
    prev_d     = prev_q;
    sidx_d     = sidx_q;
    n_d        = n_q;
    best_n_d   = best_n_q;
    best_err_d = best_err_q;
    sample_d   = sample_q;
`ifdef JT7759_ENC_DEBUG_EN
    dbg_nib_d  = dbg_nib_q;
`endif
    if (cen) begin
      if (restart) begin
        st_d   = IDLE;
        prev_d = '0;
        sidx_d = '0;
      end else begin
        case (st_q)
          IDLE: if (pcm_valid && pcm_ready) begin
            sample_d = pcm_in;
            n_d      = '0;
            best_n_d = '0;
            // Above any reachable error, so candidate 0 always seeds the best.
            best_err_d = '1;
            st_d       = SEARCH;
          end
          SEARCH: begin
            if (cand_err < best_err_q) begin
              best_err_d = cand_err;
              best_n_d   = n_q;
            end
            n_d = n_q + 4'd1;
            if (n_q == 4'hF) st_d = UPDATE;
          end
          UPDATE: begin
            prev_d = pred_next(prev_q, sidx_q, best_n_q);
            sidx_d = state_next(sidx_q, best_n_q);
`ifdef JT7759_ENC_DEBUG_EN
            dbg_nib_d = best_n_q;
`endif
            st_d = IDLE;
          end
          default: st_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      prev_q     <= '0;
      sidx_q     <= '0;
      n_q        <= '0;
      best_n_q   <= '0;
      best_err_q <= '0;
      sample_q   <= '0;
`ifdef JT7759_ENC_DEBUG_EN
      dbg_nib_q  <= '0;
`endif
    end else begin
      st_q       <= st_d;
      prev_q     <= prev_d;
      sidx_q     <= sidx_d;
      n_q        <= n_d;
      best_n_q   <= best_n_d;
      best_err_q <= best_err_d;
      sample_q   <= sample_d;
`ifdef JT7759_ENC_DEBUG_EN
      dbg_nib_q  <= dbg_nib_d;
`endif
    end
  end

`ifdef JT7759_ENC_DEBUG_EN
  assign debug_nibble = dbg_nib_q;
  assign debug_state  = sidx_q;
  assign debug_pred   = prev_q;
`endif

  jt7759_enc_pack #(
    .HI_FIRST(HI_FIRST)
  ) u_pack (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .restart   (restart),
    .flush_en  (flush && (st_q == IDLE)),
    .commit    (st_q == UPDATE),
    .nibble    (best_n_q),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

endmodule

// File: tb/tb_jt7759_encoder.sv
// Bench for jt7759_encoder: directed phrase cases plus randomized samples against a search model.
module tb_jt7759_encoder;

  logic              clk = 1'b0;
  logic              rst, cen, restart, pcm_valid, flush, dout_ready;
  logic signed [8:0] pcm_in;
  logic              pcm_ready, dout_valid;
  logic [7:0]        dout;
`ifdef JT7759_ENC_DEBUG_EN
  logic [3:0]        debug_nibble, debug_state;
  logic [8:0]        debug_pred;
`endif

  jt7759_encoder #(.HI_FIRST(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .restart   (restart),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .flush     (flush),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
`ifdef JT7759_ENC_DEBUG_EN
    ,
    .debug_nibble(debug_nibble),
    .debug_state (debug_state),
    .debug_pred  (debug_pred)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model: decoder step magnitudes for codes 0..7; codes 8..15 are their negatives.
  int mag [16][8] = '{
    '{0, 0, 1, 2, 3, 5, 7, 10},     '{0, 1, 2, 3, 4, 6, 8, 13},
    '{0, 1, 2, 4, 5, 7, 10, 15},    '{0, 1, 3, 4, 6, 9, 13, 19},
    '{0, 2, 3, 5, 8, 11, 15, 23},   '{0, 2, 4, 7, 10, 14, 19, 29},
    '{0, 3, 5, 8, 12, 16, 22, 33},  '{1, 4, 7, 10, 15, 20, 29, 43},
    '{1, 4, 8, 13, 18, 25, 35, 53}, '{1, 6, 10, 16, 22, 31, 43, 64},
    '{2, 7, 12, 19, 27, 37, 51, 76}, '{2, 9, 16, 24, 34, 46, 64, 96},
    '{3, 11, 19, 29, 41, 57, 79, 117}, '{4, 13, 24, 36, 50, 69, 96, 143},
    '{4, 16, 29, 44, 62, 85, 118, 175}, '{6, 20, 36, 54, 76, 104, 144, 214}
  };
  int adj [8] = '{-1, -1, 0, 0, 1, 2, 2, 3};

  int m_prev, m_state, m_held, m_hold;
  int exp_q[$];
  bit rand_mode = 0;
  bit acc, last_cen;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int step_val(input int st, input int n);
    return (n >= 8) ? -mag[st][n-8] : mag[st][n];
  endfunction

  task automatic model_reset();
    m_prev = 0; m_state = 0; m_held = 0; m_hold = 0;
  endtask

  task automatic model_sample(input int s);
    int best, be, c, e;
    best = 0; be = 1 << 30;
    for (int n = 0; n < 16; n++) begin
      c = clampi(m_prev + step_val(m_state, n), -256, 255);
      e = (s > c) ? s - c : c - s;
      if (e < be) begin be = e; best = n; end
    end
    m_prev  = clampi(m_prev + step_val(m_state, best), -256, 255);
    m_state = clampi(m_state + adj[best % 8], 0, 15);
    if (m_held != 0) begin exp_q.push_back(m_hold * 16 + best); m_held = 0; end
    else begin m_hold = best; m_held = 1; end
  endtask

  task automatic model_flush();
    if (m_held != 0) begin exp_q.push_back(m_hold * 16); m_held = 0; end
  endtask

  task automatic step();
    if (rand_mode) begin
      cen = ($urandom_range(0, 3) != 0);
      dout_ready = $urandom_range(0, 1);
    end
    last_cen = cen;
    acc = cen && pcm_valid && pcm_ready && !restart && !rst;
    if (dout_valid && pcm_ready) chk("ready_while_valid", 1, 0);
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) chk("unexpected_byte", int'(dout), -1);
      else chk("byte", int'(dout), exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input bit use_model);
    int t;
    t = 0;
    pcm_in = 9'(s);
    pcm_valid = 1'b1;
    do begin step(); t++; end while (!acc && t < 1000);
    if (!acc) chk("accept_timeout", 0, 1);
    pcm_valid = 1'b0;
    pcm_in = 9'($urandom);
    if (acc && use_model) model_sample(s);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!pcm_ready && t < 500) begin step(); t++; end
    if (!pcm_ready) chk("idle_timeout", int'(pcm_ready), 1);
  endtask

  task automatic pulse_ctrl(input bit do_restart, input bit do_flush);
    int t;
    t = 0;
    restart = do_restart;
    flush = do_flush;
    do begin step(); t++; end while (!last_cen && t < 100);
    restart = 1'b0;
    flush = 1'b0;
    if (do_restart) model_reset();
    else if (do_flush) model_flush();
  endtask

  task automatic flush_op();
    wait_idle();
    pulse_ctrl(1'b0, 1'b1);
  endtask

  task automatic restart_op();
    wait_idle();
    pulse_ctrl(1'b1, 1'b0);
  endtask

  task automatic expect_byte(input string tag, input int val);
    int t;
    t = 0;
    dout_ready = 1'b0;
    while (!dout_valid && t < 100) begin step(); t++; end
    chk(tag, int'(dout), val);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_hold_ready"}, int'(pcm_ready), 0);
      chk({tag, "_hold_dout"}, int'(dout), val);
    end
    dout_ready = 1'b1;
    step();
    chk({tag, "_valid_clear"}, int'(dout_valid), 0);
    chk({tag, "_ready_back"}, int'(pcm_ready), 1);
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    dout_ready = 1'b0;
    step();
    rst = 1'b0;
    dout_ready = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, s, last;
    rst = 1'b1; cen = 1'b1; restart = 1'b0; pcm_valid = 1'b0; flush = 1'b0;
    dout_ready = 1'b1; pcm_in = '0;
    model_reset();
    step(); step();
    rst = 1'b0;
    chk("reset_ready", int'(pcm_ready), 1);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_dout", int'(dout), 0);

    // Zero pair, and 17-cycle commit latency
    pulse_ctrl(1'b1, 1'b0);
    send(0, 1);
    cnt = 0;
    while (!pcm_ready && cnt < 100) begin step(); cnt++; end
    chk("latency", cnt, 17);
    send(0, 1);
    expect_byte("zero_pair", 8'h00);
    send(10, 1);
    flush_op();
    expect_byte("state_still_zero", 8'h70);

    restart_op();
    send(10, 1);
    flush_op();
    expect_byte("ten_flush", 8'h70);

    restart_op();
    send(-10, 1);
    flush_op();
    expect_byte("neg_ten_flush", 8'hF0);
    send(-10, 1);
    send(-10, 1);
    expect_byte("pred_is_neg_ten", 8'h00);

    // Saturation at full scale
    restart_op();
    for (int i = 0; i < 40; i++) send(255, 1);
    wait_idle();

    // Flush with nothing held is ignored
    restart_op();
    pulse_ctrl(1'b0, 1'b1);
    step();
    chk("empty_flush", int'(dout_valid), 0);

    // Flush during search is dropped, not deferred
    restart_op();
    send(50, 1);
    send(-30, 1);
    send(80, 1);
    flush = 1'b1; step(); step(); step(); flush = 1'b0;
    wait_idle();
    step(); step();
    chk("flush_not_kept", int'(dout_valid), 0);
    send(81, 1);
    wait_idle();

    // rst at candidate 8 abandons the sample and the held nibble
    restart_op();
    send(37, 1);
    send(100, 0);
    for (int i = 0; i < 8; i++) step();
    hard_reset();
    chk("rst_mid_ready", int'(pcm_ready), 1);
    for (int i = 0; i < 20; i++) step();
    chk("rst_mid_no_byte", int'(dout_valid), 0);
    send(10, 1);
    flush_op();
    expect_byte("after_rst", 8'h70);

    // restart+flush together: restart wins
    send(-60, 1);
    wait_idle();
    pulse_ctrl(1'b1, 1'b1);
    step();
    chk("restart_flush_no_byte", int'(dout_valid), 0);
    send(10, 1);
    flush_op();
    expect_byte("after_restart_flush", 8'h70);

    // restart mid-search
    send(-100, 1);
    send(120, 0);
    for (int i = 0; i < 5; i++) step();
    pulse_ctrl(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("restart_mid_no_byte", int'(dout_valid), 0);
    send(10, 1);
    flush_op();
    expect_byte("after_restart_mid", 8'h70);

    // Randomized phase
    restart_op();
    rand_mode = 1;
    last = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) != 0) s = int'($urandom_range(0, 511)) - 256;
      else s = clampi(last + int'($urandom_range(0, 80)) - 40, -256, 255);
      last = s;
      send(s, 1);
      if ($urandom_range(0, 9) == 0) flush_op();
      if ($urandom_range(0, 29) == 0) restart_op();
    end
    rand_mode = 0;
    cen = 1'b1;
    dout_ready = 1'b1;
    flush_op();
    wait_idle();
    step(); step();
    chk("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
